dom1_skinny_io: RTL and testbench

Device-side byte-serial shell for the first-order DOM Skinny-128-384+ core, the counterpart of the host loader/unloader bench. It accepts an opcode and seven 128-bit words (two state shares, two key shares, tweak, counter, randomness) over an 8-bit valid/ready input stream and assembles them into registers. It starts the core, waits for completion, and serializes the two ciphertext shares back over an 8-bit valid/ready output stream.

---
 rtl/dom1_skinny_io_pkg.sv | 29 ++
 rtl/dom1_skinny_io_ser.sv | 56 +++++
 rtl/dom1_skinny_io.sv | 156 +++++++++++++++
 tb/tb_dom1_skinny_io.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dom1_skinny_io_pkg.sv
// Shared constants and FSM state type for the DOM1 Skinny byte-serial shell.
// Optional build macro: DOM1_IO_UNMASK_EN (return c1^c0 instead of the two shares).
package dom1_skinny_io_pkg;

    localparam logic [7:0] OPCODE_ENC  = 8'h01;
    localparam int         N_IN_WORDS  = 7;
    localparam int         N_OUT_WORDS = 2;
    localparam int         WORD_W      = 128;
    localparam int         CNT_W       = 7;

    localparam int BYTES_IN = N_IN_WORDS * (WORD_W / 8);   // 112
    localparam int IN_W     = BYTES_IN * 8;

`ifdef DOM1_IO_UNMASK_EN
    localparam int BYTES_OUT = WORD_W / 8;                  // 16, unmasked result
`else
    localparam int BYTES_OUT = N_OUT_WORDS * (WORD_W / 8);  // 32, both shares
`endif
    localparam int OUT_W = BYTES_OUT * 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        START  = 3'd2,
        WAIT   = 3'd3,
        UNLOAD = 3'd4
    } state_t;

endpackage

// File: rtl/dom1_skinny_io_ser.sv
// Generic byte shift register with transfer counter.
// Acts as a serializer (parallel load, bytes leave from the MSB end) or a
// deserializer (bytes enter at the LSB end, so the first byte ends up on top).
// A transfer happens on a rising edge where en_i && valid_i && ready_i.
// The counter returns to 0 on the last transfer and on every parallel load,
// so it is always 0 when a new phase begins.
module dom1_skinny_io_ser #(
    parameter int W      = 256,
    parameter int NBYTES = 32,
    parameter int CNT_W  = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic         ready_i,
    input  logic [7:0]   byte_i,
    output logic [W-1:0] sreg_o,
    output logic         last_o
);

    logic [W-1:0]     sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             xfer;

    assign xfer   = en_i && valid_i && ready_i;
    assign last_o = xfer && (cnt_q == CNT_W'(NBYTES - 1));
    assign sreg_o = sreg_q;

    // Next-state: parallel load wins, otherwise shift one byte per transfer.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            sreg_d = load_data_i;
            cnt_d  = '0;
        end else if (xfer) begin
            sreg_d = {sreg_q[W-9:0], byte_i};
            cnt_d  = last_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Register update with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/dom1_skinny_io.sv
// Device-side byte-serial shell for the first-order DOM Skinny-128-384+ core.
// Loads opcode + 7 x 128-bit words, starts the core, returns the result bytes.
// Optional build macro: DOM1_IO_UNMASK_EN -- when defined, UNLOAD returns the
// 16 bytes of c1^c0; when undefined the two shares are returned untouched and
// never combined inside this block.
//
// Handshakes: a byte moves on a rising clk edge where valid && ready are both
// high. di_ready is high in IDLE and LOAD only; do_valid is high in UNLOAD
// only, and do_data stays constant while do_valid && !do_ready.
module dom1_skinny_io
    import dom1_skinny_io_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   di_data,
    input  logic         di_valid,
    output logic         di_ready,
    output logic [7:0]   do_data,
    output logic         do_valid,
    input  logic         do_ready,
    output logic [127:0] ssh1,
    output logic [127:0] ssh0,
    output logic [127:0] ksh1,
    output logic [127:0] ksh0,
    output logic [127:0] tweak,
    output logic [127:0] cnt,
    output logic [127:0] rnd,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] c1,
    input  logic [127:0] c0,
    output logic         err,
    output logic [2:0]   dbg_state
);

    state_t           state_q, state_d;
    logic             err_q, err_d;
    logic             out_load;
    logic [OUT_W-1:0] out_load_data;
    logic [IN_W-1:0]  in_sreg;
    logic [OUT_W-1:0] out_sreg;
    logic             in_last;
    logic             out_last;
    logic             unused_out_tail;

    // Input side: bytes enter MSB first, so the first word on the wire (ssh1)
    // ends up in the top 128 bits once all 112 bytes are in.
    dom1_skinny_io_ser #(
        .W      (IN_W),
        .NBYTES (BYTES_IN),
        .CNT_W  (CNT_W)
    ) u_deser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_data_i ('0),
        .en_i        (state_q == LOAD),
        .valid_i     (di_valid),
        .ready_i     (di_ready),
        .byte_i      (di_data),
        .sreg_o      (in_sreg),
        .last_o      (in_last)
    );

`ifdef DOM1_IO_UNMASK_EN
    assign out_load_data = c1 ^ c0;
`else
    assign out_load_data = {c1, c0};
`endif

    // Output side: zeros shift in behind the result, so the register is empty
    // again once the last byte has left.
    dom1_skinny_io_ser #(
        .W      (OUT_W),
        .NBYTES (BYTES_OUT),
        .CNT_W  (CNT_W)
    ) u_ser (
        .clk         (clk),
        .rst         (rst),
        .load_i      (out_load),
        .load_data_i (out_load_data),
        .en_i        (state_q == UNLOAD),
        .valid_i     (1'b1),
        .ready_i     (do_ready),
        .byte_i      (8'h00),
        .sreg_o      (out_sreg),
        .last_o      (out_last)
    );

    // Next-state, error flag and result-capture strobe.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        out_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (di_valid) begin
                    if (di_data == OPCODE_ENC) begin
                        err_d   = 1'b0;
                        state_d = LOAD;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (in_last) state_d = START;
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (core_done) begin
                    out_load = 1'b1;
                    state_d  = UNLOAD;
                end
            end
            UNLOAD: begin
                if (out_last) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and sticky error register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign di_ready   = (state_q == IDLE) || (state_q == LOAD);
    assign core_start = (state_q == START);
    assign do_valid   = (state_q == UNLOAD);
    assign do_data    = do_valid ? out_sreg[OUT_W-1 -: 8] : 8'h00;
    assign err        = err_q;
    assign dbg_state  = state_q;

    // Only the top byte of the output register is ever presented.
    assign unused_out_tail = ^out_sreg[OUT_W-9:0];

    assign ssh1  = in_sreg[IN_W-1          -: WORD_W];
    assign ssh0  = in_sreg[IN_W-1-1*WORD_W -: WORD_W];
    assign ksh1  = in_sreg[IN_W-1-2*WORD_W -: WORD_W];
    assign ksh0  = in_sreg[IN_W-1-3*WORD_W -: WORD_W];
    assign tweak = in_sreg[IN_W-1-4*WORD_W -: WORD_W];
    assign cnt   = in_sreg[IN_W-1-5*WORD_W -: WORD_W];
    assign rnd   = in_sreg[IN_W-1-6*WORD_W -: WORD_W];

endmodule

// File: tb/tb_dom1_skinny_io.sv
// Bench for dom1_skinny_io: random payloads, a stand-in core model that returns
// shares with a known XOR, random input gaps and output backpressure.
module tb_dom1_skinny_io;

`ifdef DOM1_IO_UNMASK_EN
    localparam int NB = 16;
`else
    localparam int NB = 32;
`endif
    localparam logic [127:0] SSH_C  = 128'ha3994b66ad85a3459f44e92b08f550cb;
    localparam logic [127:0] KSH_C  = 128'hab1afac2611012cd8cef952618c3ebe8;
    localparam logic [127:0] TWK_C  = 128'hab588a34a47f1ab2dfe9c8293fbea9a5;
    localparam logic [127:0] CNT_C  = 128'hdf889548cfc7ea52d296339301797449;
    localparam logic [127:0] TARGET = 128'hff38d1d24c864c4352a853690fe36e5e;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   di_data;
    logic         di_valid;
    logic         di_ready;
    logic [7:0]   do_data;
    logic         do_valid;
    logic         do_ready;
    logic [127:0] ssh1, ssh0, ksh1, ksh0, tweak, cnt, rnd;
    logic         core_start;
    logic         core_done;
    logic [127:0] c1, c0;
    logic         err;
    logic [2:0]   dbg_state;

    always #5 clk = ~clk;

    dom1_skinny_io dut (
        .clk        (clk),
        .rst        (rst),
        .di_data    (di_data),
        .di_valid   (di_valid),
        .di_ready   (di_ready),
        .do_data    (do_data),
        .do_valid   (do_valid),
        .do_ready   (do_ready),
        .ssh1       (ssh1),
        .ssh0       (ssh0),
        .ksh1       (ksh1),
        .ksh0       (ksh0),
        .tweak      (tweak),
        .cnt        (cnt),
        .rnd        (rnd),
        .core_start (core_start),
        .core_done  (core_done),
        .c1         (c1),
        .c0         (c0),
        .err        (err),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int           n_total = 0;
    int           n_bad   = 0;
    logic [7:0]   rx_q[$];
    logic [7:0]   exp_q[$];
    int           start_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [7:0]   prev_data = 8'h00;
    logic [127:0] w_cur[7];
    logic [127:0] exp_c1 = '0;
    logic [127:0] exp_c0 = '0;
    int           bp_mode = 0;
    int           ph = 0;
    int           pm;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- monitor (samples on falling edge) ----------------
    always @(negedge clk) begin
        if (rst) begin
            if (prev_stall) check_eq("do_hold", {do_valid, do_data}, {1'b1, prev_data});
            prev_stall = do_valid && !do_ready;
            prev_data  = do_data;
            if (do_valid && do_ready) rx_q.push_back(do_data);
            if (core_start) start_cnt++;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- output backpressure driver ----------------
    initial begin
        do_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ph++;
            pm = ph % 24;
            case (bp_mode)
                0:       do_ready = 1'b1;
                1:       do_ready = (pm < 10) ? ph[0] : (pm < 20) ? 1'b0 : 1'b1;
                default: do_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- stand-in core: pulses done 3..8 cycles after start ----------------
    initial begin
        core_done = 1'b0;
        c1 = '0;
        c0 = '0;
        forever begin
            @(negedge clk);
            if (core_start) begin
                repeat ($urandom_range(3, 8)) @(posedge clk);
                #1;
                c1 = exp_c1;
                c0 = exp_c0;
                core_done = 1'b1;
                @(posedge clk); #1;
                core_done = 1'b0;
                c1 = rand128();
                c0 = rand128();
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int   guard;
        logic rdy;
        repeat ($urandom_range(0, gap_max)) begin
            @(posedge clk); #1;
        end
        di_valid = 1'b1;
        di_data  = b;
        guard    = 0;
        do begin
            @(negedge clk);
            rdy = di_ready;
            @(posedge clk); #1;
            guard++;
        end while (!rdy && guard < 200);
        check_eq("in_accept", rdy, 1);
        di_valid = 1'b0;
        di_data  = 8'($urandom);
    endtask

    task automatic gen_words();
        logic [127:0] m, k;
        m = rand128();
        k = rand128();
        w_cur[0] = SSH_C ^ m;
        w_cur[1] = m;
        w_cur[2] = KSH_C ^ k;
        w_cur[3] = k;
        w_cur[4] = TWK_C;
        w_cur[5] = CNT_C;
        w_cur[6] = rand128();
        exp_c1   = rand128();
        exp_c0   = exp_c1 ^ TARGET;
    endtask

    task automatic check_words(input string tag);
        check_eq({tag, "_ssh1"},  ssh1,  w_cur[0]);
        check_eq({tag, "_ssh0"},  ssh0,  w_cur[1]);
        check_eq({tag, "_ksh1"},  ksh1,  w_cur[2]);
        check_eq({tag, "_ksh0"},  ksh0,  w_cur[3]);
        check_eq({tag, "_tweak"}, tweak, w_cur[4]);
        check_eq({tag, "_cnt"},   cnt,   w_cur[5]);
        check_eq({tag, "_rnd"},   rnd,   w_cur[6]);
    endtask

    task automatic run_txn(input int gap_max, input int bp);
        int           guard;
        logic [255:0] v;
        logic [7:0]   got;
        logic [255:0] rx_v;
        bp_mode   = bp;
        start_cnt = 0;
        rx_q.delete();
        exp_q.delete();
`ifdef DOM1_IO_UNMASK_EN
        v = {128'h0, exp_c1 ^ exp_c0};
`else
        v = {exp_c1, exp_c0};
`endif
        for (int i = 0; i < NB; i++) exp_q.push_back(v[8*NB-1-8*i -: 8]);

        send_byte(8'h01, gap_max);
        check_eq("err_after_op", err, 0);
        for (int k = 0; k < 112; k++) send_byte(w_cur[k/16][127-8*(k%16) -: 8], gap_max);
        check_eq("start_latency", core_start, 1);
        check_eq("ready_low_start", di_ready, 0);
        check_words("load");

        // bytes offered while the core is busy must be ignored
        di_valid = 1'b1;
        di_data  = 8'($urandom);
        @(posedge clk); #1;
        @(posedge clk); #1;
        di_valid = 1'b0;
        check_eq("ready_low_wait", di_ready, 0);
        check_words("wait");

        guard = 0;
        do begin
            @(posedge clk); #1;
            guard++;
        end while ((rx_q.size() < NB || do_valid) && guard < 3000);
        check_eq("unload_done", guard < 3000, 1);
        @(posedge clk); #1;
        check_eq("rx_count", rx_q.size(), NB);
        check_eq("ready_idle", di_ready, 1);
        check_eq("valid_idle", do_valid, 0);
        check_eq("start_once", start_cnt, 1);
        check_eq("err_end", err, 0);
        rx_v = '0;
        for (int i = 0; i < NB; i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            check_eq($sformatf("byte%0d", i), got, exp_q[i]);
            rx_v = {rx_v[247:0], got};
        end
`ifdef DOM1_IO_UNMASK_EN
        check_eq("unmasked", rx_v[127:0], TARGET);
`else
        check_eq("share_xor", rx_v[255:128] ^ rx_v[127:0], TARGET);
`endif
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst      = 1'b0;
        di_valid = 1'b0;
        di_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_di_ready", di_ready, 1);
        check_eq("rst_do_valid", do_valid, 0);
        check_eq("rst_do_data", do_data, 0);
        check_eq("rst_core_start", core_start, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_ssh1", ssh1, 0);
        check_eq("rst_rnd", rnd, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // nominal
        gen_words();
        run_txn(0, 0);

        // same vector with random input gaps: identical words and result
        run_txn(5, 0);

        // bad opcode then a valid transaction
        send_byte(8'h7e, 0);
        check_eq("err_set", err, 1);
        check_eq("err_ready", di_ready, 1);
        gen_words();
        run_txn(0, 0);

        // backpressure: toggling and 10-cycle stalls, then random
        gen_words();
        run_txn(0, 1);
        gen_words();
        run_txn(3, 2);

        // reset after 50 payload bytes
        gen_words();
        send_byte(8'h01, 0);
        for (int k = 0; k < 50; k++) send_byte(8'($urandom_range(1, 255)), 0);
        rst = 1'b0;
        #1;
        check_eq("mid_di_ready", di_ready, 1);
        check_eq("mid_do_valid", do_valid, 0);
        check_eq("mid_core_start", core_start, 0);
        check_eq("mid_err", err, 0);
        check_eq("mid_rnd", rnd, 0);
        check_eq("mid_cnt", cnt, 0);
        check_eq("mid_tweak", tweak, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        run_txn(0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
